// File: rtl/neurocore_pkg.sv
// Shared types and constants for the neurocore ADC front end.
// Holds the SAR controller state encoding and result width.
package neurocore_pkg;

  localparam int ADC_BITS = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRACK,
    S_TRIAL,
    S_DONE,
    S_WAIT
  } state_t;

endpackage

// File: rtl/neurocore_sync.sv
// N-flop synchronizer for asynchronous pad inputs.
// Async active-low reset clears every stage to 0.
module neurocore_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[N-2:0], d};
    end
  end

  assign q = ff[N-1];

endmodule

// File: rtl/neurocore_sar_adc_ctrl.sv
// SAR ADC controller: wake-triggered sample bursts, track/hold,
// 4-bit binary search against a synchronized comparator.
import neurocore_pkg::*;

module neurocore_sar_adc_ctrl #(
  parameter int SAMPLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int INTERVAL      = 32,
  parameter int BURST_LEN     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wake,
  input  logic                comp_in,
  output logic                sample_sw,
  output logic [ADC_BITS-1:0] dac_code,
  output logic [ADC_BITS-1:0] adc_data,
  output logic                adc_valid,
  output logic                busy
);

  localparam int PH_MAX =
    (SAMPLE_CYCLES > SYNC_STAGES + 1) ?
    SAMPLE_CYCLES : SYNC_STAGES + 1;
  localparam int PW = $clog2(PH_MAX + 1);
  localparam int IW = $clog2(INTERVAL + 1);
  localparam int BW = $clog2(BURST_LEN + 1);

  localparam logic [PW-1:0] TRK_END = PW'(SAMPLE_CYCLES - 1);
  localparam logic [PW-1:0] TRI_END = PW'(SYNC_STAGES);
  localparam logic [IW-1:0] IVL     = IW'(INTERVAL);
  localparam logic [IW-1:0] IVL_ONE = IW'(1);
  localparam logic [BW-1:0] BLEN    = BW'(BURST_LEN);
  localparam logic [BW-1:0] B_ONE   = BW'(1);

  state_t                state;
  logic [PW-1:0]         phase;
  logic [IW-1:0]         ivl;
  logic [BW-1:0]         burst;
  logic                  rearm;
  logic [1:0]            bit_idx;
  logic                  comp_s;
  logic [ADC_BITS-1:0]   cur_mask;
  logic [ADC_BITS-1:0]   nxt_mask;
  logic [ADC_BITS-1:0]   trial_res;

  neurocore_sync #(
    .N(SYNC_STAGES)
  ) u_comp_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (comp_in),
    .q    (comp_s)
  );

  // dac_code already holds the kept bits plus the bit under trial
  always_comb begin
    cur_mask  = ADC_BITS'(1) << bit_idx;
    nxt_mask  = ADC_BITS'(1) << (bit_idx - 2'd1);
    trial_res = comp_s ? dac_code : (dac_code & ~cur_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      phase     <= '0;
      ivl       <= '0;
      burst     <= '0;
      rearm     <= 1'b0;
      bit_idx   <= '0;
      sample_sw <= 1'b0;
      dac_code  <= '0;
      adc_data  <= '0;
      adc_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      adc_valid <= 1'b0;
      if (ivl != IVL) ivl <= ivl + 1'b1;
      unique case (state)
        S_IDLE: begin
          if (wake) begin
            state     <= S_TRACK;
            burst     <= BLEN;
            rearm     <= 1'b0;
            busy      <= 1'b1;
            sample_sw <= 1'b1;
            dac_code  <= '0;
            phase     <= '0;
            ivl       <= IVL_ONE;
          end
        end
        S_TRACK: begin
          if (wake) rearm <= 1'b1;
          if (phase == TRK_END) begin
            state     <= S_TRIAL;
            phase     <= '0;
            sample_sw <= 1'b0;
            bit_idx   <= 2'd3;
            dac_code  <= ADC_BITS'(8);
          end else begin
            phase <= phase + 1'b1;
          end
        end
        S_TRIAL: begin
          if (wake) rearm <= 1'b1;
          if (phase == TRI_END) begin
            phase <= '0;
            if (bit_idx == 2'd0) begin
              state     <= S_DONE;
              adc_data  <= trial_res;
              adc_valid <= 1'b1;
              dac_code  <= '0;
            end else begin
              bit_idx  <= bit_idx - 2'd1;
              dac_code <= trial_res | nxt_mask;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
        S_DONE: begin
          rearm <= 1'b0;
          if (!wake && !rearm && burst <= B_ONE) begin
            state <= S_IDLE;
            burst <= '0;
            busy  <= 1'b0;
          end else begin
            // a pending retrigger counts the finished sample as in-flight
            if (wake || rearm) burst <= BLEN;
            else               burst <= burst - 1'b1;
            if (ivl >= IVL) begin
              state     <= S_TRACK;
              sample_sw <= 1'b1;
              dac_code  <= '0;
              phase     <= '0;
              ivl       <= IVL_ONE;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (wake) burst <= BLEN;
          if (ivl >= IVL) begin
            state     <= S_TRACK;
            sample_sw <= 1'b1;
            dac_code  <= '0;
            phase     <= '0;
            ivl       <= IVL_ONE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/neurocore_sar_adc_ctrl.md
# neurocore_sar_adc_ctrl

Successive-approximation ADC controller that sits directly upstream of `neurocore_field_sensor` and produces its `adc_data[3:0]` / `adc_valid` stream. It samples the electrode front-end in bursts triggered by the wake comparator, and drives the track/hold switch and a 4-bit capacitive DAC. It also resolves the asynchronous comparator output into 4-bit codes.

## Interface
- `SAMPLE_CYCLES`, default 4: track-phase length in cycles.
- `SYNC_STAGES`, default 2: comparator synchronizer depth (≥2).
- `INTERVAL`, default 32: cycles from one TRACK start to the next.
- `BURST_LEN`, default 16: samples per wake burst (≥1).

Ports:
- `clk`  in  1  single system clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `wake`  in  1  wake pulse from event comparator, synchronous to `clk`.
- `comp_in`  in  1  SAR comparator, asynchronous; 1 = input ≥ DAC level.
- `sample_sw`  out  1  track/hold switch, 1 = track.
- `dac_code`  out  4  SAR DAC trial code.
- `adc_data`  out  4  last conversion result; held until the next result.
- `adc_valid`  out  1  one-cycle strobe marking a new `adc_data`.
- `busy`  out  1  burst in progress.

## Operation
- States: IDLE, TRACK, TRIAL, DONE, WAIT.
- IDLE: `wake`=1 at an edge → TRACK. The burst counter loads BURST_LEN.
- TRACK: `sample_sw`=1 and `dac_code`=0 for SAMPLE_CYCLES cycles → TRIAL with bit index 3.
- TRIAL for bit i, each trial lasting SYNC_STAGES+1 cycles:
  - `dac_code` = kept bits | (1<<i).
  - On the last cycle, sample the synchronized comparator; if 1, keep bit i.
  - After bit 0 → DONE.
- DONE, one cycle:
  - `adc_data` ← result, `adc_valid`=1, `dac_code` ← 0.
  - Burst counter decrements.
  - If the counter is now 0 → IDLE; else → WAIT.
- WAIT: hold until INTERVAL cycles have elapsed since the current TRACK start → TRACK.
  - If INTERVAL ≤ conversion length, TRACK follows DONE immediately with no WAIT cycle.
- Retrigger: `wake`=1 in any non-IDLE state reloads the counter so that BURST_LEN further samples follow the in-flight one.
  - The in-flight conversion is never aborted.
  - `wake` coincident with the final DONE also reloads, and the burst continues.
  - `wake` held high retriggers every cycle, so the burst never ends while it is high.
- `busy`=1 in every state except IDLE.
- Comparator path: SYNC_STAGES flops, reset to 0. The raw `comp_in` never reaches FSM logic.
- Arithmetic:
  - Result register is 4 bits.
  - Interval counter is clog2(INTERVAL+1) bits and saturates.
  - Burst counter is clog2(BURST_LEN+1) bits and never underflows.

## Timing
- Reset: all outputs are 0 (`sample_sw`, `dac_code`, `adc_data`, `adc_valid`, `busy`), state is IDLE, all counters are 0. Assertion mid-conversion discards the partial result with no `adc_valid`.
- Cycle numbering: `wake` sampled at edge E0; "cycle n" is the cycle after edge E(n-1). With defaults:
  - `sample_sw`=1 in cycles 1–4.
  - Bit 3 trial in cycles 5–7, bit 2 in 8–10, bit 1 in 11–13, bit 0 in 14–16.
  - `adc_valid`=1 in cycle 17.
- General latency from wake to `adc_valid`: SAMPLE_CYCLES + 4·(SYNC_STAGES+1) + 1 cycles.
- Next TRACK starts in cycle 1+INTERVAL, i.e. cycle 33 with defaults.
- `busy` rises in cycle 1 and falls in the cycle after the final DONE.
- All outputs are registered. Nothing combinational goes from `comp_in` or `wake` to any output.

## Structure
- Package `neurocore_pkg` holds the FSM state enum and `ADC_BITS`=4.
- Sub-module `neurocore_sync`: parameterized N-flop synchronizer with async active-low reset. It is reused for `comp_in` and is available to other pad inputs.
- One FSM, three counters (phase, interval, burst), and the result register live in the top module.

## Test plan
- Comparator model, input level 9 (`comp_in` = 9 ≥ `dac_code`), single `wake` → `dac_code` sequence 8, 12, 10, 9; `adc_data`=9 with `adc_valid` in cycle 17.
- Input levels 0 and 15 → `adc_data` 0 and 15 respectively; trial codes are never 0.
- Single `wake`, defaults → exactly 16 `adc_valid` pulses, 32 cycles apart. `busy` falls 1 cycle after the 16th pulse, then no further activity for 200 cycles.
- `wake` during the 10th sample's TRIAL → that sample completes, then 16 more follow, for 26 pulses total.
- `rst_n` low in cycle 9 → all outputs read 0 within the same cycle and no `adc_valid` occurs. After release, a new `wake` gives the correct result in cycle 17.
- `comp_in` toggling asynchronously to `clk` → no X on outputs, and exactly one `adc_valid` per conversion.
